// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480 VGA timing generator: counter widths,
// phase boundaries (last count of each phase) and FSM state encodings.
package vga_timing_pkg;

  localparam int unsigned HCNT_W = 12;
  localparam int unsigned VCNT_W = 10;

  // Horizontal phases, in clk (4 clk per pixel)
  localparam int unsigned H_DISP_LAST  = 2559;
  localparam int unsigned H_FP_LAST    = 2623;
  localparam int unsigned H_SYNC_LAST  = 3007;
  localparam int unsigned H_TOTAL_LAST = 3199;

  // Vertical phases, in lines
  localparam int unsigned V_DISP_LAST  = 479;
  localparam int unsigned V_FP_LAST    = 489;
  localparam int unsigned V_SYNC_LAST  = 491;
  localparam int unsigned V_TOTAL_LAST = 520;

  // FSM state encodings
  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

endpackage

// File: rtl/vga_line_counter.sv
// Vertical line counter: advances once per completed line, wraps after the
// last line of the frame, and is held at zero while cleared.
module vga_line_counter
  import vga_timing_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              line_end,
  output logic [VCNT_W-1:0] v_cnt
);

  localparam logic [VCNT_W-1:0] V_TOTAL_C = VCNT_W'(V_TOTAL_LAST);

  logic [VCNT_W-1:0] v_cnt_q;
  logic [VCNT_W-1:0] v_cnt_d;

  // Next line number: clear wins, otherwise step/wrap on each line end
  always_comb begin
    v_cnt_d = v_cnt_q;
    if (clear) begin
      v_cnt_d = '0;
    end else if (line_end) begin
      v_cnt_d = (v_cnt_q == V_TOTAL_C) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Line count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_cnt_q <= '0;
    end else begin
      v_cnt_q <= v_cnt_d;
    end
  end

  assign v_cnt = v_cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA 640x480 timing generator at 4 clk per pixel. A three-state FSM gates
// the horizontal/vertical counters; every output is a registered decode of
// the counters held in the previous cycle. Dropping enable lets the current
// frame finish; the generator parks in IDLE at the frame wrap.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  // Last clk of each horizontal phase. Defaults give the standard 800-pixel
  // line; a shorter line can be configured by overriding them.
  parameter int unsigned H_DISP_END  = H_DISP_LAST,
  parameter int unsigned H_FP_END    = H_FP_LAST,
  parameter int unsigned H_SYNC_END  = H_SYNC_LAST,
  parameter int unsigned H_TOTAL_END = H_TOTAL_LAST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            hsync,
  output logic            vsync,
  output logic            disp_en,
  output logic [9:0]      pixel_x,
  output logic [9:0]      pixel_y,
  output logic            pixel_tick,
  output logic            frame_start,
  output logic            busy,
  output logic [ST_W-1:0] dbg_state
);

  localparam logic [HCNT_W-1:0] H_DISP_C  = HCNT_W'(H_DISP_END);
  localparam logic [HCNT_W-1:0] H_FP_C    = HCNT_W'(H_FP_END);
  localparam logic [HCNT_W-1:0] H_SYNC_C  = HCNT_W'(H_SYNC_END);
  localparam logic [HCNT_W-1:0] H_TOTAL_C = HCNT_W'(H_TOTAL_END);
  localparam logic [VCNT_W-1:0] V_DISP_C  = VCNT_W'(V_DISP_LAST);
  localparam logic [VCNT_W-1:0] V_FP_C    = VCNT_W'(V_FP_LAST);
  localparam logic [VCNT_W-1:0] V_SYNC_C  = VCNT_W'(V_SYNC_LAST);
  localparam logic [VCNT_W-1:0] V_TOTAL_C = VCNT_W'(V_TOTAL_LAST);

  logic [ST_W-1:0]   state_q, state_d;
  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt;
  logic              running;
  logic              line_end;
  logic              frame_end;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_en_q, disp_en_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       frame_start_q, frame_start_d;
  logic       busy_q, busy_d;

  assign running   = (state_q == ST_RUN) || (state_q == ST_STOP_PEND);
  assign line_end  = running && (h_cnt_q == H_TOTAL_C);
  assign frame_end = line_end && (v_cnt == V_TOTAL_C);

  // FSM: a stop request only takes effect at the frame wrap, including when
  // it arrives on the very last cycle of the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_RUN;
      ST_RUN:       if (!enable) state_d = frame_end ? ST_IDLE : ST_STOP_PEND;
      ST_STOP_PEND: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Horizontal count: runs only while active, held at zero in IDLE
  always_comb begin
    h_cnt_d = '0;
    if (running && !line_end) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // State and horizontal counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
    end
  end

  vga_line_counter u_line_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (!running),
    .line_end (line_end),
    .v_cnt    (v_cnt)
  );

  // Output decode of the current counters; idle levels when not running
  always_comb begin
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    disp_en_d     = 1'b0;
    pixel_x_d     = '0;
    pixel_y_d     = '0;
    pixel_tick_d  = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    if (running) begin
      busy_d        = 1'b1;
      hsync_d       = !((h_cnt_q > H_FP_C) && (h_cnt_q <= H_SYNC_C));
      vsync_d       = !((v_cnt > V_FP_C) && (v_cnt <= V_SYNC_C));
      disp_en_d     = (h_cnt_q <= H_DISP_C) && (v_cnt <= V_DISP_C);
      pixel_tick_d  = (h_cnt_q[1:0] == 2'd0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt == '0);
      if (disp_en_d) begin
        pixel_x_d = h_cnt_q[HCNT_W-1:2];
        pixel_y_d = v_cnt;
      end
    end
  end

  // Output registers: one clk behind the counters they decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      disp_en_q     <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_tick_q  <= pixel_tick_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. One instance uses the standard 3200-clk line to
// measure horizontal timing over a few lines; a second instance uses a 16-clk
// line (display 0..7, front porch 8..9, sync 10..11, back porch 12..15) with
// the standard 521-line frame, so whole frames, stop/restart and mid-frame
// reset fit in a short run.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int F_LINE   = 3200;
  localparam int SH_LINE  = 16;
  localparam int SH_FRAME = 521 * SH_LINE;  // 8336 clk

  logic clk;
  logic rst_full, en_full, rst_short, en_short;

  logic       f_hsync, f_vsync, f_disp_en, f_pixel_tick, f_frame_start, f_busy;
  logic [9:0] f_pixel_x, f_pixel_y;
  logic [1:0] f_dbg_state;
  logic       s_hsync, s_vsync, s_disp_en, s_pixel_tick, s_frame_start, s_busy;
  logic [9:0] s_pixel_x, s_pixel_y;
  logic [1:0] s_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected frame_start sample positions for the short instance
  logic [31:0] exp_q[$];

  // Short-instance monitor statistics
  int s_idx;
  int fs_extra, vs_cur, vs_runs, vs_run_len, vs_fall_first;
  int de_cur, de_runs, de_run_bad, busy_fall_at, idle_bad, py_max, px_max;

  vga_timing_ctrl u_full (
    .clk         (clk),
    .reset       (rst_full),
    .enable      (en_full),
    .hsync       (f_hsync),
    .vsync       (f_vsync),
    .disp_en     (f_disp_en),
    .pixel_x     (f_pixel_x),
    .pixel_y     (f_pixel_y),
    .pixel_tick  (f_pixel_tick),
    .frame_start (f_frame_start),
    .busy        (f_busy),
    .dbg_state   (f_dbg_state)
  );

  vga_timing_ctrl #(
    .H_DISP_END  (7),
    .H_FP_END    (9),
    .H_SYNC_END  (11),
    .H_TOTAL_END (15)
  ) u_short (
    .clk         (clk),
    .reset       (rst_short),
    .enable      (en_short),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .disp_en     (s_disp_en),
    .pixel_x     (s_pixel_x),
    .pixel_y     (s_pixel_y),
    .pixel_tick  (s_pixel_tick),
    .frame_start (s_frame_start),
    .busy        (s_busy),
    .dbg_state   (s_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    fs_extra = 0; vs_cur = 0; vs_runs = 0; vs_run_len = 0; vs_fall_first = -1;
    de_cur = 0; de_runs = 0; de_run_bad = 0; busy_fall_at = -1; idle_bad = 0;
    py_max = 0; px_max = 0;
    exp_q.delete();
  endtask

  // Fold the current short-instance sample (position s_idx) into the stats
  task automatic acc_short();
    if (s_frame_start) begin
      if (exp_q.size() == 0) fs_extra++;
      else check_eq("short_frame_start_pos", 32'(s_idx), exp_q.pop_front());
    end
    if (!s_vsync) begin
      if (vs_cur == 0 && vs_fall_first < 0) vs_fall_first = s_idx;
      vs_cur++;
    end else if (vs_cur != 0) begin
      vs_runs++;
      vs_run_len = vs_cur;
      vs_cur = 0;
    end
    if (s_disp_en) begin
      de_cur++;
    end else if (de_cur != 0) begin
      de_runs++;
      if (de_cur != 8) de_run_bad++;
      de_cur = 0;
    end
    if (!s_busy && busy_fall_at < 0) busy_fall_at = s_idx;
    if (!s_busy && (!s_hsync || !s_vsync || s_disp_en || s_pixel_tick || s_frame_start ||
                    s_pixel_x != 10'd0 || s_pixel_y != 10'd0)) idle_bad++;
    if (int'(s_pixel_y) > py_max) py_max = int'(s_pixel_y);
    if (int'(s_pixel_x) > px_max) px_max = int'(s_pixel_x);
  endtask

  task automatic mon_short(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      s_idx++;
      acc_short();
    end
  endtask

  initial begin
    int last_tick, tick_gap_bad, n_ticks;
    int hs_run, hs_runs, hs_run_bad, hs_fall_first, hs_fall_last, hs_period_bad;
    int de_bad, px_bad, py_bad, vs_low, fs_cnt;

    last_tick = 0; tick_gap_bad = 0; n_ticks = 0;
    hs_run = 0; hs_runs = 0; hs_run_bad = 0; hs_fall_first = -1; hs_fall_last = 0;
    hs_period_bad = 0; de_bad = 0; px_bad = 0; py_bad = 0; vs_low = 0; fs_cnt = 0;
    s_idx = 0;
    clear_stats();

    // ---- Full-size instance: reset values, start-up, horizontal timing ----
    rst_full = 1'b0; en_full = 1'b1; rst_short = 1'b0; en_short = 1'b0;
    repeat (3) step();
    check_eq("rst_hsync", 32'(f_hsync), 32'd1);
    check_eq("rst_vsync", 32'(f_vsync), 32'd1);
    check_eq("rst_busy", 32'(f_busy), 32'd0);
    check_eq("rst_state", 32'(f_dbg_state), 32'(ST_IDLE));
    check_eq("rst_others", 32'({f_disp_en, f_pixel_x, f_pixel_y, f_pixel_tick, f_frame_start}), 32'd0);

    rst_full = 1'b1;
    step();
    check_eq("start_state_run", 32'(f_dbg_state), 32'(ST_RUN));
    check_eq("start_fs_not_yet", 32'(f_frame_start), 32'd0);
    step();
    check_eq("start_frame_start", 32'(f_frame_start), 32'd1);
    check_eq("start_busy", 32'(f_busy), 32'd1);

    for (int s = 0; s < 3 * F_LINE + 8; s++) begin
      int pos;
      int exp_px;
      int exp_py;
      logic exp_de;
      if (s > 0) step();
      pos    = s % F_LINE;
      exp_de = (pos < 2560);
      exp_px = exp_de ? pos / 4 : 0;
      exp_py = exp_de ? s / F_LINE : 0;
      if (f_disp_en != exp_de) de_bad++;
      if (int'(f_pixel_x) != exp_px) px_bad++;
      if (int'(f_pixel_y) != exp_py) py_bad++;
      if (f_pixel_tick) begin
        if (n_ticks > 0 && s - last_tick != 4) tick_gap_bad++;
        last_tick = s;
        n_ticks++;
      end
      if (!f_hsync) begin
        if (hs_run == 0) begin
          if (hs_fall_first < 0) hs_fall_first = s;
          else if (s - hs_fall_last != F_LINE) hs_period_bad++;
          hs_fall_last = s;
        end
        hs_run++;
      end else if (hs_run != 0) begin
        hs_runs++;
        if (hs_run != 384) hs_run_bad++;
        hs_run = 0;
      end
      if (!f_vsync) vs_low++;
      if (f_frame_start) fs_cnt++;
    end
    check_eq("tick_gap_bad", 32'(tick_gap_bad), 32'd0);
    check_eq("tick_count", 32'(n_ticks), 32'd2402);
    check_eq("hsync_first_fall", 32'(hs_fall_first), 32'd2624);
    check_eq("hsync_runs", 32'(hs_runs), 32'd3);
    check_eq("hsync_len_bad", 32'(hs_run_bad), 32'd0);
    check_eq("hsync_period_bad", 32'(hs_period_bad), 32'd0);
    check_eq("disp_en_bad", 32'(de_bad), 32'd0);
    check_eq("pixel_x_bad", 32'(px_bad), 32'd0);
    check_eq("pixel_y_bad", 32'(py_bad), 32'd0);
    check_eq("vsync_low_early", 32'(vs_low), 32'd0);
    check_eq("frame_start_count", 32'(fs_cnt), 32'd1);
    rst_full = 1'b0;

    // ---- Short-line instance: one full frame ----
    en_short = 1'b1;
    step();
    rst_short = 1'b1;
    step();
    check_eq("b1_state_run", 32'(s_dbg_state), 32'(ST_RUN));
    step();
    check_eq("b1_frame_start", 32'(s_frame_start), 32'd1);
    s_idx = 0;
    clear_stats();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'(SH_FRAME));
    acc_short();
    mon_short(SH_FRAME + 4);
    check_eq("b1_fs_seen", 32'(exp_q.size()), 32'd0);
    check_eq("b1_fs_extra", 32'(fs_extra), 32'd0);
    check_eq("b1_vsync_fall", 32'(vs_fall_first), 32'd7840);
    check_eq("b1_vsync_runs", 32'(vs_runs), 32'd1);
    check_eq("b1_vsync_len", 32'(vs_run_len), 32'd32);
    check_eq("b1_disp_rows", 32'(de_runs), 32'd480);
    check_eq("b1_disp_len_bad", 32'(de_run_bad), 32'd0);
    check_eq("b1_busy_fall", 32'(busy_fall_at), 32'hFFFF_FFFF);
    check_eq("b1_pixel_y_max", 32'(py_max), 32'd479);
    check_eq("b1_pixel_x_max", 32'(px_max), 32'd1);

    // ---- Enable dropped at line 100 of frame 2: frame completes, then idle ----
    mon_short(SH_FRAME + 100 * SH_LINE - s_idx);
    clear_stats();
    en_short = 1'b0;
    mon_short(2 * SH_FRAME + 40 - s_idx);
    check_eq("b2_busy_fall", 32'(busy_fall_at), 32'(2 * SH_FRAME));
    check_eq("b2_vsync_fall", 32'(vs_fall_first), 32'(SH_FRAME + 7840));
    check_eq("b2_vsync_len", 32'(vs_run_len), 32'd32);
    check_eq("b2_fs_extra", 32'(fs_extra), 32'd0);
    check_eq("b2_idle_bad", 32'(idle_bad), 32'd0);
    check_eq("b2_state_idle", 32'(s_dbg_state), 32'(ST_IDLE));

    // ---- Drop at line 100, restore at line 300; then drop on the last cycle ----
    en_short = 1'b1;
    step();
    step();
    check_eq("b3_frame_start", 32'(s_frame_start), 32'd1);
    s_idx = 0;
    clear_stats();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'(SH_FRAME));
    acc_short();
    mon_short(100 * SH_LINE);
    en_short = 1'b0;
    mon_short(200 * SH_LINE);
    en_short = 1'b1;
    mon_short(2 * SH_FRAME - 2 - s_idx);
    en_short = 1'b0;
    mon_short(42);
    check_eq("b3_fs_seen", 32'(exp_q.size()), 32'd0);
    check_eq("b3_fs_extra", 32'(fs_extra), 32'd0);
    check_eq("b3_busy_fall", 32'(busy_fall_at), 32'(2 * SH_FRAME));
    check_eq("b3_vsync_fall", 32'(vs_fall_first), 32'd7840);
    check_eq("b3_vsync_runs", 32'(vs_runs), 32'd2);
    check_eq("b3_idle_bad", 32'(idle_bad), 32'd0);

    // ---- Reset pulse mid-frame at line 200, clk 5 of the line ----
    en_short = 1'b1;
    step();
    step();
    check_eq("b4_frame_start", 32'(s_frame_start), 32'd1);
    s_idx = 0;
    clear_stats();
    acc_short();
    mon_short(200 * SH_LINE + 5);
    check_eq("b4_pre_pixel_y", 32'(s_pixel_y), 32'd200);
    check_eq("b4_pre_pixel_x", 32'(s_pixel_x), 32'd1);
    check_eq("b4_pre_disp_en", 32'(s_disp_en), 32'd1);
    #2;
    rst_short = 1'b0;
    #1;
    check_eq("b4_rst_hsync", 32'(s_hsync), 32'd1);
    check_eq("b4_rst_vsync", 32'(s_vsync), 32'd1);
    check_eq("b4_rst_busy", 32'(s_busy), 32'd0);
    check_eq("b4_rst_state", 32'(s_dbg_state), 32'(ST_IDLE));
    check_eq("b4_rst_others", 32'({s_disp_en, s_pixel_x, s_pixel_y, s_pixel_tick, s_frame_start}), 32'd0);
    repeat (3) step();
    rst_short = 1'b1;
    step();
    check_eq("b4_restart_state", 32'(s_dbg_state), 32'(ST_RUN));
    step();
    check_eq("b4_restart_fs", 32'(s_frame_start), 32'd1);
    check_eq("b4_restart_pixel_y", 32'(s_pixel_y), 32'd0);
    s_idx = 0;
    clear_stats();
    exp_q.push_back(32'd0);
    acc_short();
    mon_short(3 * SH_LINE);
    check_eq("b4_fs_seen", 32'(exp_q.size()), 32'd0);
    check_eq("b4_fs_extra", 32'(fs_extra), 32'd0);
    check_eq("b4_busy_fall", 32'(busy_fall_at), 32'hFFFF_FFFF);
    check_eq("b4_disp_rows", 32'(de_runs), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock at 100 MHz; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1 bit: level request to run video timing.
REQ-004 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-005 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-006 SHALL have port disp_en, output, 1 bit: high while inside the 640x480 visible area.
REQ-007 SHALL have port pixel_x, output, 10 bits: visible column 0..639, 0 outside the visible area.
REQ-008 SHALL have port pixel_y, output, 10 bits: visible row 0..479, 0 outside the visible area.
REQ-009 SHALL have port pixel_tick, output, 1 bit: one-clk pulse marking each 25 MHz pixel slot.
REQ-010 SHALL have port frame_start, output, 1 bit: one-clk pulse at the start of every frame.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL keep a 12-bit h_cnt, 0..3199, incrementing every clk in RUN/STOP_PEND and wrapping 3199->0; one pixel SHALL be 4 clk.
REQ-013 SHALL keep a 10-bit v_cnt, 0..520, incrementing when h_cnt wraps and wrapping 520->0.
REQ-014 SHALL use horizontal phases in clk: DISPLAY 0..2559, FRONT_PORCH 2560..2623, SYNC 2624..3007, BACK_PORCH 3008..3199.
REQ-015 SHALL use vertical phases in lines: DISPLAY 0..479, FRONT_PORCH 480..489, SYNC 490..491, BACK_PORCH 492..520.
REQ-016 SHALL drive all outputs from registers: outputs in cycle n+1 decode the counters held in cycle n (1-clk latency).
REQ-017 SHALL drive hsync=0 iff h_cnt is in the horizontal SYNC phase, and vsync=0 iff v_cnt is in the vertical SYNC phase.
REQ-018 SHALL drive disp_en=1 iff both counters are in their DISPLAY phase; pixel_x=h_cnt[11:2] and pixel_y=v_cnt when disp_en=1, else 0.
REQ-019 SHALL pulse pixel_tick when h_cnt[1:0]==0, in all phases.
REQ-020 SHALL pulse frame_start when h_cnt==0 and v_cnt==0.
REQ-021 SHALL implement FSM states IDLE, RUN and STOP_PEND.
REQ-022 SHALL transition IDLE->RUN when enable=1, with counters at 0, so the first RUN cycle is h_cnt=0, v_cnt=0.
REQ-023 SHALL transition RUN->STOP_PEND when enable=0; the current frame SHALL complete unchanged.
REQ-024 SHALL transition STOP_PEND->IDLE on the cycle the counters wrap from (3199,520) to (0,0), clearing the counters.
REQ-025 SHALL return STOP_PEND->RUN with no timing discontinuity if enable returns to 1 before the frame end.
REQ-026 SHALL, when enable deasserts exactly on the final cycle (3199,520), go to IDLE at the wrap and not start a new frame.
REQ-027 SHALL hold hsync=1, vsync=1, disp_en=0, pixel_x=0, pixel_y=0, pixel_tick=0, frame_start=0 and busy=0 in IDLE.

Reset
REQ-028 SHALL, while reset=0, force the FSM to IDLE, h_cnt=0, v_cnt=0, hsync=1, vsync=1, and all other outputs to 0.
REQ-029 SHALL abort the frame immediately on reset assertion mid-frame, with no completion of the frame.
REQ-030 SHALL, after reset release with enable=1, enter RUN on the first clk edge.

Structure
REQ-031 SHALL define all phase boundaries (2559, 2623, 3007, 3199, 479, 489, 491, 520) and the FSM state encodings as constants in shared package vga_timing_pkg.
REQ-032 SHALL place the vertical line counter in sub-module vga_line_counter (inputs: clk, reset, clear, line_end; output: v_cnt).

Verification
REQ-033 SHALL check: reset release with enable=1 -> frame_start pulse 1 clk after the first RUN cycle; pixel_tick period 4 clk.
REQ-034 SHALL check: full frame run -> hsync low for 384 clk per line, period 3200 clk; vsync low for 6400 clk, period 1,667,200 clk.
REQ-035 SHALL check: disp_en high for 2560 clk on each of rows 0..479; pixel_x steps 0..639, each value held 4 clk.
REQ-036 SHALL check: enable dropped at line 100 -> frame completes, busy falls at the wrap, hsync=vsync=1 thereafter.
REQ-037 SHALL check: enable dropped at line 100 and restored at line 300 -> frame period unchanged, busy never falls.
REQ-038 SHALL check: reset pulse at h_cnt=1500, v_cnt=200 -> all outputs at reset values within the same cycle; a new frame starts cleanly after release.
